humansized_muldiv_seq: RTL and testbench

- Sequencer (initiator) for the human-sized shift-add multiplier/divider datapath. Takes a start/operands request, then drives the datapath's op, Di and ci inputs cycle by cycle.
- Reads back PM and rF, then returns a registered result with a done pulse.
- Prototype of the midgetv mult/div control; pairs 1:1 with the datapath in simulation.

---
 rtl/humansized_muldiv_pkg.sv | 32 +++
 rtl/humansized_muldiv_bitcnt.sv | 28 ++
 rtl/humansized_muldiv_seq.sv | 166 ++++++++++++++++
 tb/tb_humansized_muldiv_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/humansized_muldiv_pkg.sv
// Shared encodings for the human-sized shift-add multiplier/divider:
// datapath op codes, sequencer state codes and the func select.
`timescale 1ns/1ps
package humansized_muldiv_pkg;

   // Datapath op word: [0]=load, [2:1]=shifttype, [4:3]=addtype
   localparam logic [4:0] OP_LOAD = 5'b00001;
   localparam logic [4:0] OP_MADD = 5'b00000;
   localparam logic [4:0] OP_SRL  = 5'b00010;
   localparam logic [4:0] OP_SRA  = 5'b00100;
   localparam logic [4:0] OP_SLL  = 5'b00110;
   localparam logic [4:0] OP_DSUB = 5'b10000;

   localparam logic FUNC_MUL = 1'b0;
   localparam logic FUNC_DIV = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LOAD = 3'd1;
   localparam state_t ST_MA   = 3'd2;
   localparam state_t ST_MS   = 3'd3;
   localparam state_t ST_DS   = 3'd4;
   localparam state_t ST_DD   = 3'd5;
   localparam state_t ST_FIN  = 3'd6;
   localparam state_t ST_DZ   = 3'd7;

   function automatic logic is_shift_op(input logic [4:0] op);
      return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
   endfunction

endpackage

// File: rtl/humansized_muldiv_bitcnt.sv
// Loadable down-counter with zero flag; tracks the remaining shift-add
// iterations of the multiply/divide loops.
`timescale 1ns/1ps
module humansized_muldiv_bitcnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   assign zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/humansized_muldiv_seq.sv
// Sequencer for the human-sized shift-add mult/div datapath: steps the
// datapath through W multiply or restoring-divide iterations and returns the result.
`timescale 1ns/1ps
module humansized_muldiv_seq
   import humansized_muldiv_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           func,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   res_hi,
   output logic [W-1:0]   res_lo,
   output logic           dz,
   output logic [4:0]     dp_op,
   output logic [W-1:0]   dp_Di,
   output logic           dp_ci,
   input  logic [2*W-1:0] dp_PM,
   input  logic           dp_rF
);

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          func_q;
   logic          accept;
   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_zero;
   logic [CW-1:0] cnt_val;
   logic [CW-1:0] cnt;
   logic          last_iter;
   logic          fin_mul_div;
   logic          fin_dz;
   logic          unused_rf;

   assign unused_rf   = dp_rF;
   assign busy        = (state != ST_IDLE);
   assign last_iter   = (cnt == CW'(1));
   assign fin_mul_div = (state == ST_FIN);
   assign fin_dz      = (state == ST_DZ) && cnt_zero;

   humansized_muldiv_bitcnt #(.CW(CW)) u_bitcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;
      dp_op     = OP_MADD;
      dp_Di     = '0;
      dp_ci     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               cnt_load = 1'b1;
               // DZ waits one cycle in place of LOAD so its done lands after edge 2
               if (func == FUNC_DIV && b == '0) begin
                  state_nxt = ST_DZ;
                  cnt_val   = CW'(1);
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            dp_op     = OP_LOAD;
            dp_Di     = a_q;
            cnt_load  = 1'b1;
            cnt_val   = CW'(W);
            state_nxt = (func_q == FUNC_MUL) ? ST_MA : ST_DS;
         end
         ST_MA: begin
            dp_op     = OP_MADD;
            dp_Di     = b_q;
            state_nxt = ST_MS;
         end
         ST_MS: begin
            dp_op     = OP_SRL;
            cnt_dec   = 1'b1;
            state_nxt = last_iter ? ST_FIN : ST_MA;
         end
         ST_DS: begin
            dp_op     = OP_SLL;
            state_nxt = ST_DD;
         end
         ST_DD: begin
            // ~b with carry-in forms the two's-complement subtract of the divisor
            dp_op     = OP_DSUB;
            dp_Di     = ~b_q;
            dp_ci     = 1'b1;
            cnt_dec   = 1'b1;
            state_nxt = last_iter ? ST_FIN : ST_DS;
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
         end
         ST_DZ: begin
            if (cnt_zero) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_q    <= a;
         b_q    <= b;
         func_q <= func;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done   <= 1'b0;
         dz     <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
      end else begin
         done <= 1'b0;
         if (fin_mul_div) begin
            res_hi <= dp_PM[2*W-1:W];
            res_lo <= dp_PM[W-1:0];
            dz     <= 1'b0;
            done   <= 1'b1;
         end else if (fin_dz) begin
            res_hi <= a_q;
            res_lo <= '1;
            dz     <= 1'b1;
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_humansized_muldiv_seq.sv
// Bench for humansized_muldiv_seq paired with a behavioural shift-add datapath;
// results are scoreboarded against plain multiply/divide arithmetic.
`timescale 1ns/1ps
module tb_humansized_muldiv_seq;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   localparam logic [4:0] T_LOAD = 5'b00001;
   localparam logic [4:0] T_MADD = 5'b00000;
   localparam logic [4:0] T_SRL  = 5'b00010;
   localparam logic [4:0] T_SLL  = 5'b00110;
   localparam logic [4:0] T_DSUB = 5'b10000;

   typedef struct packed {
      logic          f;
      logic          z;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  hi;
      logic [W-1:0]  lo;
      logic [31:0]   acc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           func = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy, done, dz, dp_ci, dp_rF;
   logic [W-1:0]   res_hi, res_lo, dp_Di;
   logic [4:0]     dp_op;
   logic [2*W-1:0] dp_PM;

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   always_ff @(posedge clk) edge_cnt <= edge_cnt + 1;

   humansized_muldiv_seq #(.W(W), .CW(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .func   (func),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .dz     (dz),
      .dp_op  (dp_op),
      .dp_Di  (dp_Di),
      .dp_ci  (dp_ci),
      .dp_PM  (dp_PM),
      .dp_rF  (dp_rF)
   );

   // Behavioural datapath: {rF,rP,rM} with load, shifts and the two adders
   logic [W-1:0] rP, rM;
   logic         rF;
   logic [W:0]   madd_sum;
   logic [W+1:0] dsub_sum;

   assign madd_sum = {1'b0, rP} + {1'b0, dp_Di} + {{W{1'b0}}, dp_ci};
   assign dsub_sum = {1'b0, rF, rP} + {2'b01, dp_Di} + {{(W+1){1'b0}}, dp_ci};
   assign dp_PM    = {rP, rM};
   assign dp_rF    = rF;

   always_ff @(posedge clk) begin
      if (dp_op[0]) begin
         rP <= '0;
         rF <= 1'b0;
         rM <= dp_Di;
      end else if (dp_op[2:1] == 2'b01) begin
         {rF, rP, rM} <= {1'b0, rF, rP, rM[W-1:1]};
      end else if (dp_op[2:1] == 2'b11) begin
         {rF, rP, rM} <= {rP, rM, 1'b0};
      end else if (dp_op[2:1] == 2'b10) begin
         {rF, rP, rM} <= {rF, rF, rP, rM[W-1:1]};
      end else if (dp_op[4:3] == 2'b10) begin
         if (dsub_sum[W+1]) begin
            rF    <= dsub_sum[W];
            rP    <= dsub_sum[W-1:0];
            rM[0] <= 1'b1;
         end
      end else if (rM[0]) begin
         {rF, rP} <= madd_sum;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic f, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] hi, input logic [W-1:0] lo, input logic z);
      exp_t e;
      e.f = f; e.a = x; e.b = y; e.hi = hi; e.lo = lo; e.z = z; e.acc = '0;
      return e;
   endfunction

   function automatic exp_t model(input logic f, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] p;
      if (!f) begin
         p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         return mk(f, x, y, p[2*W-1:W], p[W-1:0], 1'b0);
      end else if (y == '0) begin
         return mk(f, x, y, x, {W{1'b1}}, 1'b1);
      end
      return mk(f, x, y, x % y, x / y, 1'b0);
   endfunction

   task automatic issue(input exp_t e_in);
      exp_t e;
      int   guard;
      e = e_in;
      guard = 0;
      while (busy && guard < 4*W + 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("idle_wait", 32'(busy), 0);
      start = 1'b1; func = e.f; a = e.a; b = e.b;
      e.acc = 32'(edge_cnt + 1);
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; func = 1'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   // Monitor: protocol counters per transaction, results popped on done
   int         n_load, n_srl, n_sll, n_dsub, bad_ci, bad_di, bad_hold;
   logic [W-1:0] last_hi, last_lo;

   initial begin : monitor
      exp_t cur;
      n_load = 0; n_srl = 0; n_sll = 0; n_dsub = 0; bad_ci = 0; bad_di = 0; bad_hold = 0;
      last_hi = '0; last_lo = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            n_load = 0; n_srl = 0; n_sll = 0; n_dsub = 0; bad_ci = 0; bad_di = 0; bad_hold = 0;
            last_hi = '0; last_lo = '0;
         end else begin
            if (dp_op == T_LOAD) n_load++;
            if (dp_op == T_SRL)  n_srl++;
            if (dp_op == T_SLL)  n_sll++;
            if (dp_op == T_DSUB) n_dsub++;
            if (dp_ci !== (dp_op == T_DSUB)) bad_ci++;
            if (sb.size() != 0) begin
               cur = sb[0];
               if (dp_op == T_LOAD && dp_Di !== cur.a) bad_di++;
               if (dp_op == T_DSUB && dp_Di !== ~cur.b) bad_di++;
            end
            if (!done && (res_hi !== last_hi || res_lo !== last_lo)) bad_hold++;
            if (done) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done res_hi=0x%0h res_lo=0x%0h with no request pending", res_hi, res_lo);
               end else begin
                  cur = sb.pop_front();
                  chk("res_hi", 32'(res_hi), 32'(cur.hi));
                  chk("res_lo", 32'(res_lo), 32'(cur.lo));
                  chk("dz", 32'(dz), 32'(cur.z));
                  chk("busy_in_done", 32'(busy), 0);
                  chk("latency", 32'(edge_cnt) - cur.acc, cur.z ? 2 : 2*W + 2);
                  chk("load_count", n_load, cur.z ? 0 : 1);
                  chk("srl_count", n_srl, (!cur.z && !cur.f) ? W : 0);
                  chk("sll_count", n_sll, (!cur.z && cur.f) ? W : 0);
                  chk("dsub_count", n_dsub, (!cur.z && cur.f) ? W : 0);
                  chk("ci_misuse", bad_ci, 0);
                  chk("di_value", bad_di, 0);
                  chk("result_hold", bad_hold, 0);
               end
               last_hi = res_hi; last_lo = res_lo;
               n_load = 0; n_srl = 0; n_sll = 0; n_dsub = 0; bad_ci = 0; bad_di = 0; bad_hold = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #950000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic         rf;
      logic [W-1:0] ra, rb;
      int           guard;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_dz", 32'(dz), 0);
      chk("rst_res_hi", 32'(res_hi), 0);
      chk("rst_res_lo", 32'(res_lo), 0);
      chk("rst_dp_op", 32'(dp_op), 32'(T_MADD));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      issue(mk(1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0));
      issue(mk(1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0));
      issue(mk(1'b1, 8'd200, 8'd7,   8'd4,  8'd28, 1'b0));
      issue(mk(1'b1, 8'd5,   8'd0,   8'd5,  8'hFF, 1'b1));
      issue(mk(1'b0, 8'd3,   8'd4,   8'd0,  8'd12, 1'b0));
      repeat (3) begin @(posedge clk); #1; end
      chk("busy_midop", 32'(busy), 1);
      start = 1'b1; func = 1'b1; a = 8'd99; b = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      issue(mk(1'b1, 8'd100, 8'd9,   8'd1,  8'd11,  1'b0));
      issue(mk(1'b1, 8'd255, 8'd1,   8'd0,  8'd255, 1'b0));
      issue(mk(1'b0, 8'd0,   8'd200, 8'd0,  8'd0,   1'b0));
      issue(mk(1'b1, 8'd7,   8'd200, 8'd7,  8'd0,   1'b0));
      issue(mk(1'b1, 8'd0,   8'd0,   8'd0,  8'hFF,  1'b1));
      issue(mk(1'b0, 8'd255, 8'd1,   8'd0,  8'hFF,  1'b0));

      // Reset mid-multiply, low before edge 9 of the operation
      issue(model(1'b0, 8'd77, 8'd91));
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_res_hi", 32'(res_hi), 0);
      chk("midrst_res_lo", 32'(res_lo), 0);
      chk("midrst_dz", 32'(dz), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(model(1'b0, 8'd200, 8'd3));
      issue(model(1'b1, 8'd250, 8'd16));

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         rf = 1'($urandom);
         ra = W'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
         issue(model(rf, ra, rb));
         if ($urandom_range(0, 15) == 0) begin
            @(posedge clk); #1;
            if (busy) begin
               start = 1'b1; func = 1'($urandom); a = W'($urandom); b = W'($urandom);
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
      end

      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_queue", sb.size(), 0);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
